// File: rtl/column_ctrl_pkg.sv
// Shared encodings for the note column: controller states, TOP_POS codes,
// per-cell point values and the step LFSR polynomial.
package column_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    localparam logic [2:0] TOP_POS_NONE = 3'b000;
    localparam logic [2:0] TOP_POS_0    = 3'b001;
    localparam logic [2:0] TOP_POS_1    = 3'b010;
    localparam logic [2:0] TOP_POS_2    = 3'b011;
    localparam logic [2:0] TOP_POS_3    = 3'b100;
    localparam logic [2:0] TOP_POS_4    = 3'b101;

    localparam logic [3:0] NO_POINT = 4'b0000;
    localparam logic [3:0] PLUS_ONE = 4'b0001;
    localparam logic [3:0] PLUS_TWO = 4'b0010;
    localparam logic [3:0] NEG_TWO  = 4'b1110;

    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        lfsr_next = (s >> 1) ^ (s[0] ? LFSR_TAPS : 8'h00);
    endfunction

    function automatic logic lfsr_next_lsb(input logic [7:0] s);
        logic [7:0] n;
        n = lfsr_next(s);
        lfsr_next_lsb = n[0];
    endfunction

    function automatic logic [2:0] top_pos_of(input logic [4:0] l);
        if (l[4])      top_pos_of = TOP_POS_4;
        else if (l[3]) top_pos_of = TOP_POS_3;
        else if (l[2]) top_pos_of = TOP_POS_2;
        else if (l[1]) top_pos_of = TOP_POS_1;
        else if (l[0]) top_pos_of = TOP_POS_0;
        else           top_pos_of = TOP_POS_NONE;
    endfunction

endpackage

// File: rtl/column_ctrl_lfsr.sv
// 8-bit step LFSR: reloads SEED on reset or load, advances once per step.
module step_lfsr
    import column_ctrl_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] state
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            state <= SEED;
        end else if (advance) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/column_ctrl.sv
// Column controller: game FSM, note-step timing and spawn, key synchronizer,
// score/miss accumulation from the five cells' point outputs.
module column_ctrl
    import column_ctrl_pkg::*;
#(
    parameter int unsigned STEP_DIV   = 16,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5,
    parameter int unsigned MISS_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        key_raw,
    input  logic [4:0]  lights,
    input  logic [19:0] pts,
    output logic        spawn,
    output logic        key_pulse,
    output logic [2:0]  top_pos,
    output logic [7:0]  score,
    output logic [3:0]  misses,
    output logic        game_over
);

    localparam int unsigned DIV_W     = $clog2(STEP_DIV);
    localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(STEP_DIV - 1);
    localparam logic [3:0]  MISS_LIM4 = 4'(MISS_LIMIT);

    logic [1:0]        state, state_next;
    logic [DIV_W-1:0]  div;
    logic [7:0]        lfsr_state;
    logic              key_s1, key_s2, key_s2_d;
    logic              enter_play, step, stay_play;
    logic signed [6:0] pts_sum;
    logic [2:0]        neg_cnt;
    logic signed [9:0] score_sum;
    logic [7:0]        score_next;
    logic [4:0]        misses_sum;
    logic [3:0]        misses_next;

    assign top_pos   = top_pos_of(lights);
    assign game_over = (state == ST_OVER);

    always_comb begin
        pts_sum = '0;
        neg_cnt = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            pts_sum = pts_sum + {{3{pts[4*i+3]}}, pts[4*i +: 4]};
            if (pts[4*i +: 4] == NEG_TWO) neg_cnt = neg_cnt + 3'd1;
        end
        score_sum = $signed({2'b00, score}) + $signed({{3{pts_sum[6]}}, pts_sum});
        if (score_sum < 0)            score_next = '0;
        else if (score_sum > 10'sd255) score_next = '1;
        else                          score_next = score_sum[7:0];
        misses_sum  = {1'b0, misses} + {2'b00, neg_cnt};
        misses_next = (misses_sum > 5'd15) ? 4'hF : misses_sum[3:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_PLAY:  if (misses_next >= MISS_LIM4) state_next = ST_OVER;
            default:  if (start) state_next = ST_PLAY;
        endcase
    end

    assign enter_play = (state != ST_PLAY) && (state_next == ST_PLAY);
    assign step       = (state == ST_PLAY) && (div == DIV_TERM);
    // Pulses are suppressed on the edge that leaves PLAY so they never show in OVER
    assign stay_play  = (state == ST_PLAY) && (state_next == ST_PLAY);

    step_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (enter_play),
        .advance (step),
        .state   (lfsr_state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            score     <= '0;
            misses    <= '0;
            div       <= '0;
            key_s1    <= 1'b0;
            key_s2    <= 1'b0;
            key_s2_d  <= 1'b0;
            spawn     <= 1'b0;
            key_pulse <= 1'b0;
        end else begin
            state     <= state_next;
            key_s1    <= key_raw;
            key_s2    <= key_s1;
            key_s2_d  <= key_s2;
            key_pulse <= key_s2 & ~key_s2_d & stay_play;
            spawn     <= step & stay_play & lfsr_next_lsb(lfsr_state) & ~lights[0];
            if (enter_play) begin
                score  <= '0;
                misses <= '0;
                div    <= '0;
            end else if (state == ST_PLAY) begin
                score  <= score_next;
                misses <= misses_next;
                div    <= step ? '0 : div + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_column_ctrl.sv
// Scoreboard bench for column_ctrl: an integer reference model predicts each
// edge's outputs into a queue, popped and compared after the edge.
module tb_column_ctrl;

    localparam int STEP_DIV   = 16;
    localparam int MISS_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst, start, key_raw;
    logic [4:0]  lights;
    logic [19:0] pts;
    logic        spawn, key_pulse, game_over;
    logic [2:0]  top_pos;
    logic [7:0]  score;
    logic [3:0]  misses;

    column_ctrl #(.STEP_DIV(16), .LFSR_SEED(8'hA5), .MISS_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .key_raw(key_raw),
        .lights(lights), .pts(pts), .spawn(spawn), .key_pulse(key_pulse),
        .top_pos(top_pos), .score(score), .misses(misses), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        int score;
        int misses;
        int spawn;
        int kp;
        int go;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    int m_state, m_score, m_misses, m_div;
    logic [7:0] m_lfsr;
    bit m_s1, m_s2, m_s2d, m_spawn, m_kp;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_top(input logic [4:0] l);
        int r = 0;
        for (int i = 0; i < 5; i++) if (l[i]) r = i + 1;
        return r;
    endfunction

    // Reference model: one rising edge, given the inputs currently driven
    task automatic model_edge();
        exp_t e;
        int sum, neg, ns, sc, ms, v;
        bit stp, fb, kp_new;
        logic [7:0] nl;
        if (rst) begin
            m_state = 0; m_score = 0; m_misses = 0; m_div = 0; m_lfsr = 8'hA5;
            m_s1 = 0; m_s2 = 0; m_s2d = 0; m_spawn = 0; m_kp = 0;
        end else begin
            sum = 0; neg = 0;
            for (int i = 0; i < 5; i++) begin
                v = int'((pts >> (4 * i)) & 20'hF);
                if (v == 14) neg++;
                if (v > 7) v -= 16;
                sum += v;
            end
            ns = m_state; sc = m_score; ms = m_misses; stp = 0; nl = m_lfsr;
            if (m_state == 1) begin
                sc = m_score + sum;
                if (sc < 0) sc = 0;
                if (sc > 255) sc = 255;
                ms = m_misses + neg;
                if (ms > 15) ms = 15;
                if (ms >= MISS_LIMIT) ns = 2;
                stp = (m_div == STEP_DIV - 1);
            end else if (start) begin
                ns = 1;
            end
            if (stp) begin
                fb = nl[0];
                nl = nl >> 1;
                if (fb) nl = nl ^ 8'b1011_1000;
            end
            m_spawn = stp && ns == 1 && nl[0] && !lights[0];
            kp_new  = m_s2 && !m_s2d && m_state == 1 && ns == 1;
            m_kp = kp_new;
            m_s2d = m_s2; m_s2 = m_s1; m_s1 = key_raw;
            if (m_state == 1) begin
                m_score = sc; m_misses = ms; m_lfsr = nl;
                m_div = stp ? 0 : m_div + 1;
            end else if (ns == 1) begin
                m_score = 0; m_misses = 0; m_div = 0; m_lfsr = 8'hA5;
            end
            m_state = ns;
        end
        e.score = m_score; e.misses = m_misses; e.spawn = int'(m_spawn);
        e.kp = int'(m_kp); e.go = (m_state == 2) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("score",     int'(score),     e.score);
        check("misses",    int'(misses),    e.misses);
        check("spawn",     int'(spawn),     e.spawn);
        check("key_pulse", int'(key_pulse), e.kp);
        check("game_over", int'(game_over), e.go);
    endtask

    int cnt, at;

    initial begin
        rst = 1; start = 0; key_raw = 0; lights = '0; pts = '0;
        tick(); tick();
        check("rst_score", int'(score), 0);
        check("rst_misses", int'(misses), 0);
        check("rst_go", int'(game_over), 0);
        check("rst_spawn", int'(spawn), 0);
        rst = 0;

        lights = 5'b00101; #1 check("top_idle_a", int'(top_pos), 3);
        lights = 5'b10000; #1 check("top_idle_b", int'(top_pos), 5);
        lights = 5'b00000; #1 check("top_idle_c", int'(top_pos), 0);

        key_raw = 1; cnt = 0;
        for (int k = 0; k < 10; k++) begin tick(); cnt += int'(key_pulse); end
        check("idle_key_pulses", cnt, 0);
        key_raw = 0;
        repeat (3) tick();

        start = 1; tick(); start = 0;
        check("enter_score", int'(score), 0);
        for (int k = 1; k <= 40; k++) begin
            tick();
            check("spawn_step", int'(spawn), (k == 32) ? 1 : 0);
        end

        lights = 5'b00101; #1 check("top_play_a", int'(top_pos), 3);
        lights = 5'b10000; #1 check("top_play_b", int'(top_pos), 5);
        lights = 5'b00000; #1 check("top_play_c", int'(top_pos), 0);

        key_raw = 1; cnt = 0; at = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (key_pulse) begin cnt++; at = k; end
        end
        check("play_key_pulses", cnt, 1);
        check("play_key_latency", at, 3);
        key_raw = 0;

        pts = 20'h77777; repeat (7) tick();
        pts = 20'h00005; tick();
        check("score_250", int'(score), 250);
        pts = 20'h00021;
        tick(); check("sat_253", int'(score), 253);
        tick(); check("sat_255a", int'(score), 255);
        tick(); check("sat_255b", int'(score), 255);
        pts = 20'h88888; repeat (6) tick();
        pts = 20'h00099; tick();
        check("score_1", int'(score), 1);
        pts = 20'h00E00; tick();
        check("floor_0", int'(score), 0);
        check("miss_1", int'(misses), 1);
        repeat (2) tick();
        check("miss_3", int'(misses), 3);
        pts = 20'h00EE7; tick();
        check("end_misses", int'(misses), 5);
        check("end_score", int'(score), 3);
        check("end_go", int'(game_over), 1);
        pts = 20'h77777; repeat (3) tick();
        check("frozen_score", int'(score), 3);
        pts = '0; start = 1; tick(); start = 0;
        check("restart_go", int'(game_over), 0);
        check("restart_score", int'(score), 0);
        check("restart_misses", int'(misses), 0);

        for (int k = 0; k < 300; k++) begin
            pts = 20'($urandom);
            if ($urandom_range(0, 3) != 0)
                for (int i = 0; i < 5; i++)
                    if (pts[4*i +: 4] == 4'hE) pts[4*i +: 4] = 4'h1;
            lights  = 5'($urandom);
            key_raw = ($urandom_range(0, 3) == 0);
            start   = ($urandom_range(0, 15) == 0);
            #1 check("top_rand", int'(top_pos), exp_top(lights));
            tick();
        end

        pts = 20'h00011; lights = '0; key_raw = 0; start = 1; tick();
        start = 1; key_raw = 1; tick(); tick();
        rst = 1; tick();
        check("rst_mid_score", int'(score), 0);
        check("rst_mid_misses", int'(misses), 0);
        check("rst_mid_kp", int'(key_pulse), 0);
        check("rst_mid_spawn", int'(spawn), 0);
        check("rst_mid_go", int'(game_over), 0);
        rst = 0; start = 0; tick(); tick();
        check("rst_idle_hold", int'(score), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/column_ctrl.md
COLUMN_CTRL -- requirements
Module: column_ctrl

Interface
REQ-001 Parameter STEP_DIV, default 16, clock cycles per note step (>=2).
REQ-002 Parameter LFSR_SEED, default 8'hA5, nonzero LFSR reload value.
REQ-003 Parameter MISS_LIMIT, default 4, miss count that ends the game (1..15).
REQ-004 Clock  in  1  sole clock; all state changes on rising edge.
REQ-005 Reset  in  1  reset is synchronous and active-high.
REQ-006 start  in  1  level; sampled high in IDLE or OVER begins a new game.
REQ-007 key_raw  in  1  asynchronous player key, active-high.
REQ-008 lights  in  5  lighton of column cells, bit0 = bottom cell, bit4 = top cell.
REQ-009 pts  in  20  per-cell signed 4-bit points, cell i at bits [4i+3:4i].
REQ-010 spawn  out  1  one-cycle BL pulse to bottom cell.
REQ-011 key_pulse  out  1  one-cycle synchronized press to all cells.
REQ-012 top_pos  out  3  TOP_POS to all cells.
REQ-013 score  out  8  unsigned running score.
REQ-014 misses  out  4  unsigned miss count.
REQ-015 game_over  out  1  high while in OVER.

Function
REQ-016 SHALL implement states IDLE, PLAY, OVER; IDLE->PLAY and OVER->PLAY on start sampled high; PLAY->OVER when misses reaches MISS_LIMIT; start ignored in PLAY.
REQ-017 On entry to PLAY SHALL clear score, misses and step divider and reload the LFSR with LFSR_SEED in the same edge.
REQ-018 top_pos SHALL be combinational in every state: 3'b000 when lights==0, else 1 + index of highest set bit (3'b001..3'b101).
REQ-019 In PLAY the divider SHALL count 0..STEP_DIV-1 and wrap; at terminal count a step occurs.
REQ-020 On each step the 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) SHALL advance once; spawn SHALL be registered high for the next cycle only if the new LFSR bit0 is 1 and lights[0] is 0 at that step.
REQ-021 key_raw SHALL pass two synchronizer flops; key_pulse SHALL be registered high for exactly one cycle on synchronized 0->1, i.e. high in the cycle after the 3rd edge sampling key_raw high; one pulse per press.
REQ-022 key_pulse and spawn SHALL be 0 outside PLAY; synchronizer keeps running in all states.
REQ-023 In PLAY each cycle SHALL sign-extend the five pts fields, sum them (range -40..+35, 7-bit signed) and add to score, saturating at 0 and 255.
REQ-024 In PLAY misses SHALL increase by the number of cells whose pts equals 4'b1110 (-2) that cycle, saturating at 15.
REQ-025 The cycle whose update makes misses >= MISS_LIMIT SHALL still apply its score update; next state is OVER.
REQ-026 In IDLE and OVER score and misses SHALL hold; game_over = 1 only in OVER.

Reset
REQ-027 Reset SHALL force state IDLE, score 0, misses 0, divider 0, LFSR LFSR_SEED, synchronizer flops 0, spawn 0, key_pulse 0, game_over 0; asserted mid-game it takes priority over start and all updates.

Structure
REQ-028 Shared package SHALL hold the state encoding, TOP_POS codes (none, _0.._4) and point constants (no_point 0, plus_one 1, plus_two 2, neg_two -2), used by cells and column_ctrl.
REQ-029 LFSR SHALL be a sub-module step_lfsr (load, advance, 8-bit state out); everything else stays in column_ctrl.

Verification
REQ-030 Reset 2 cycles, start=1 one cycle -> PLAY; spawn only on step edges (every 16 cycles), first step LFSR A5->new state per polynomial, spawn matches its bit0.
REQ-031 lights=5'b00101 -> top_pos=3'b011; lights=5'b10000 -> 3'b101; lights=0 -> 3'b000, in IDLE and PLAY.
REQ-032 key_raw held high 10 cycles in PLAY -> exactly one key_pulse, 3 edges after first high sample; same press in IDLE -> none.
REQ-033 score=250, pts cell0=+1 and cell1=+2 for 3 cycles -> 253, 255, 255; score=1, pts cell2=-2 -> 0 and misses +1.
REQ-034 MISS_LIMIT=4, misses=3, one cycle with two cells at -2 -> misses=5, that cycle's score applied, game_over=1 next cycle, score frozen; start -> PLAY with score=0, misses=0.
REQ-035 Reset asserted in PLAY with start=1 and key_pulse pending -> IDLE, all outputs at reset values next cycle.
